// File: rtl/rx_ctrl_unit.sv
// UART receive controller: times the 9 mid-bit shift strobes of a frame, checks the
// stop bit, gates the RX buffer load and tracks data_ready / overrun / framing status.
module rx_ctrl_unit #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic stop_bit,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic overrun_error,
  output logic framing_error,
  output logic busy
);

  localparam int TW = $clog2(2 * CLKS_PER_BIT);
  // First wait lands on the middle of data bit 0 (start bit plus half a bit).
  localparam logic [TW-1:0] START_LOAD = TW'(CLKS_PER_BIT + CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LOAD   = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic [3:0]     bit_cnt_reg, bit_cnt_next;
  logic           data_ready_reg, overrun_reg, framing_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_bit_detected) begin
          state_next   = RECV;
          timer_next   = START_LOAD;
          bit_cnt_next = '0;
        end
      end
      RECV: begin
        if (timer_reg == '0) begin
          timer_next   = BIT_LOAD;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          // The ninth strobe (stop bit) ends reception.
          if (bit_cnt_reg == 4'd8) begin
            state_next = CHECK;
          end
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_strobe = (state_reg == RECV) && (timer_reg == '0);
    load_buffer  = (state_reg == CHECK) && stop_bit;
    busy         = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      framing_reg    <= 1'b0;
    end else begin
      if (load_buffer) begin
        data_ready_reg <= 1'b1;
      end else if (data_read) begin
        data_ready_reg <= 1'b0;
      end

      if (load_buffer && data_ready_reg && !data_read) begin
        overrun_reg <= 1'b1;
      end else if (data_read) begin
        overrun_reg <= 1'b0;
      end

      if ((state_reg == IDLE) && start_bit_detected) begin
        framing_reg <= 1'b0;
      end else if ((state_reg == CHECK) && !stop_bit) begin
        framing_reg <= 1'b1;
      end
    end
  end

  assign data_ready    = data_ready_reg;
  assign overrun_error = overrun_reg;
  assign framing_error = framing_reg;

endmodule

// File: tb/tb_rx_ctrl_unit.sv
// Bench for rx_ctrl_unit at CLKS_PER_BIT 10 and 16, checked every cycle against a
// frame-timing model derived from the detect cycle and the bit period.
module tb_rx_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;
  logic det[2], stp[2], rd[2];
  logic so[2], lb[2], dr[2], ov[2], fe[2], bz[2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit m_busy[2], m_dr[2], m_ov[2], m_fe[2];
  int t0[2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      rx_ctrl_unit #(.CLKS_PER_BIT(gi == 0 ? 10 : 16)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (det[gi]),
        .stop_bit           (stp[gi]),
        .data_read          (rd[gi]),
        .shift_strobe       (so[gi]),
        .load_buffer        (lb[gi]),
        .data_ready         (dr[gi]),
        .overrun_error      (ov[gi]),
        .framing_error      (fe[gi]),
        .busy               (bz[gi])
      );
    end
  endgenerate

  function automatic int np(int i);
    return (i == 0) ? 10 : 16;
  endfunction

  // Cycle (relative to the detect cycle) in which the stop bit is evaluated.
  function automatic int chk_rel(int i);
    return 19 * np(i) / 2 + 1;
  endfunction

  function automatic logic [5:0] dut_vec(int i);
    return {so[i], lb[i], dr[i], ov[i], fe[i], bz[i]};
  endfunction

  // Expected {strobe, load, data_ready, overrun, framing, busy} for the current cycle.
  function automatic logic [5:0] exp_vec(int i);
    int  n   = np(i);
    int  rel = cyc - t0[i];
    logic s, l;
    s = m_busy[i] && rel >= 3 * n / 2 && rel <= 19 * n / 2 && ((rel - 3 * n / 2) % n == 0);
    l = m_busy[i] && rel == chk_rel(i) && stp[i];
    return {s, l, m_dr[i], m_ov[i], m_fe[i], m_busy[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_dr[i] = 0; m_ov[i] = 0; m_fe[i] = 0; t0[i] = 0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int  rel = cyc - t0[i];
      bit  chk = m_busy[i] && rel == chk_rel(i);
      bit  ld  = chk && stp[i];
      if (n_rst) begin
        if (ld && m_dr[i] && !rd[i]) m_ov[i] = 1;
        else if (rd[i])              m_ov[i] = 0;
        if (ld)         m_dr[i] = 1;
        else if (rd[i]) m_dr[i] = 0;
        if (!m_busy[i] && det[i]) begin
          m_busy[i] = 1; t0[i] = cyc; m_fe[i] = 0;
        end else if (chk) begin
          m_busy[i] = 0;
          if (!stp[i]) m_fe[i] = 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(int i);
    n_rst = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      det[i] = 1'($urandom % 2); stp[i] = 1'($urandom % 2); rd[i] = 1'($urandom % 2);
      @(negedge clk);
      checks++;
      if (dut_vec(i) !== 6'b0) begin
        failures++;
        $display("FAIL reset_hold inst%0d cyc=%0d got=%b exp=%b", i, cyc, dut_vec(i), 6'b0);
      end
      advance();
    end
    det[i] = 1'b0; rd[i] = 1'b0; stp[i] = 1'b1; n_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec(i) !== exp_vec(i) || bz[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_release inst%0d cyc=%0d got=%b exp=%b", i, cyc, dut_vec(i), exp_vec(i));
      end
      advance();
    end
  endtask

  task automatic test_good_frame(int i);
    int cnt = 0;
    rd[i] = 1'b1; det[i] = 1'b0; stp[i] = 1'b1;
    advance();
    rd[i] = 1'b0;
    for (int k = 0; k <= chk_rel(i) + 1; k++) begin
      det[i] = (k == 0);
      @(negedge clk);
      if (so[i] === 1'b1) cnt++;
      checks++;
      if (dut_vec(i) !== exp_vec(i)) begin
        failures++;
        $display("FAIL good_frame inst%0d rel=%0d got=%b exp=%b", i, k, dut_vec(i), exp_vec(i));
      end
      advance();
    end
    checks++;
    if (cnt != 9) begin
      failures++;
      $display("FAIL strobe_count inst%0d got=%0d exp=9", i, cnt);
    end
    checks++;
    if ({dr[i], ov[i], fe[i], bz[i]} !== 4'b1000) begin
      failures++;
      $display("FAIL good_frame_status inst%0d got=%b exp=1000", i, {dr[i], ov[i], fe[i], bz[i]});
    end
  endtask

  task automatic test_framing(int i);
    for (int f = 0; f < 2; f++) begin
      stp[i] = (f == 1);
      for (int k = 0; k <= chk_rel(i) + 1; k++) begin
        det[i] = (k == 0);
        @(negedge clk);
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL framing_frame%0d inst%0d rel=%0d got=%b exp=%b", f, i, k, dut_vec(i), exp_vec(i));
        end
        advance();
      end
      checks++;
      if (fe[i] !== (f == 0)) begin
        failures++;
        $display("FAIL framing_flag%0d inst%0d got=%b exp=%b", f, i, fe[i], (f == 0));
      end
    end
  endtask

  task automatic test_overrun(int i);
    rd[i] = 1'b1; det[i] = 1'b0; stp[i] = 1'b1;
    advance();
    rd[i] = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k <= chk_rel(i) + 1; k++) begin
        det[i] = (k == 0);
        @(negedge clk);
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL overrun_frame%0d inst%0d rel=%0d got=%b exp=%b", f, i, k, dut_vec(i), exp_vec(i));
        end
        advance();
      end
    end
    checks++;
    if ({dr[i], ov[i]} !== 2'b11) begin
      failures++;
      $display("FAIL overrun_set inst%0d got=%b exp=11", i, {dr[i], ov[i]});
    end
    rd[i] = 1'b1;
    advance();
    rd[i] = 1'b0;
    checks++;
    if ({dr[i], ov[i]} !== 2'b00) begin
      failures++;
      $display("FAIL overrun_clear inst%0d got=%b exp=00", i, {dr[i], ov[i]});
    end
  endtask

  task automatic test_load_with_read(int i);
    stp[i] = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k <= chk_rel(i) + 1; k++) begin
        det[i] = (k == 0);
        rd[i]  = (f == 1) && (k == chk_rel(i));
        @(negedge clk);
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL load_read_frame%0d inst%0d rel=%0d got=%b exp=%b", f, i, k, dut_vec(i), exp_vec(i));
        end
        advance();
      end
    end
    rd[i] = 1'b0;
    checks++;
    if ({dr[i], ov[i]} !== 2'b10) begin
      failures++;
      $display("FAIL load_read_status inst%0d got=%b exp=10", i, {dr[i], ov[i]});
    end
  endtask

  task automatic test_reset_midframe(int i);
    int cnt = 0;
    stp[i] = 1'b1; rd[i] = 1'b0;
    for (int k = 0; k < 50; k++) begin
      det[i] = (k == 0) || ($urandom % 4 == 0);
      @(negedge clk);
      checks++;
      if (dut_vec(i) !== exp_vec(i)) begin
        failures++;
        $display("FAIL extra_detect inst%0d rel=%0d got=%b exp=%b", i, k, dut_vec(i), exp_vec(i));
      end
      advance();
    end
    det[i] = 1'b0;
    n_rst  = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec(i) !== 6'b0) begin
        failures++;
        $display("FAIL midframe_reset inst%0d cyc=%0d got=%b exp=%b", i, cyc, dut_vec(i), 6'b0);
      end
      advance();
    end
    n_rst = 1'b1;
    for (int k = 0; k < 2 * np(i); k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec(i) !== exp_vec(i)) begin
        failures++;
        $display("FAIL post_reset_idle inst%0d cyc=%0d got=%b exp=%b", i, cyc, dut_vec(i), exp_vec(i));
      end
      advance();
    end
    for (int k = 0; k <= chk_rel(i) + 1; k++) begin
      det[i] = (k == 0);
      @(negedge clk);
      if (so[i] === 1'b1) cnt++;
      checks++;
      if (dut_vec(i) !== exp_vec(i)) begin
        failures++;
        $display("FAIL post_reset_frame inst%0d rel=%0d got=%b exp=%b", i, k, dut_vec(i), exp_vec(i));
      end
      advance();
    end
    checks++;
    if (cnt != 9) begin
      failures++;
      $display("FAIL post_reset_strobes inst%0d got=%0d exp=9", i, cnt);
    end
  endtask

  task automatic test_random(int i);
    for (int k = 0; k < 800; k++) begin
      det[i] = ($urandom % 25 == 0);
      rd[i]  = ($urandom % 10 == 0);
      stp[i] = ($urandom % 4 != 0);
      @(negedge clk);
      checks++;
      if (dut_vec(i) !== exp_vec(i)) begin
        failures++;
        $display("FAIL random inst%0d cyc=%0d got=%b exp=%b", i, cyc, dut_vec(i), exp_vec(i));
      end
      advance();
    end
    det[i] = 1'b0; rd[i] = 1'b0; stp[i] = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      det[i] = 1'b0; stp[i] = 1'b1; rd[i] = 1'b0;
    end
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      test_reset(i);
      test_good_frame(i);
      test_framing(i);
      test_overrun(i);
      test_load_with_read(i);
      test_reset_midframe(i);
      test_random(i);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
